// File: rtl/axi_txn_limiter_if.sv
// AXI4 bus bundle shared by the limiter's upstream and downstream ports.
// Master drives request channels (AW, W, AR) and the B/R readies.
interface AXI_BUS #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_USER_WIDTH = 6
);
  localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0]     w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_txn_limiter.sv
// Outstanding-transaction limiter for an AXI4 port with a drain/flush handshake.
// Payload is passed straight through; only AR/AW valid/ready are gated.
module axi_txn_limiter #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_USER_WIDTH = 6,
  parameter int AXI_ID_WIDTH   = 6,
  parameter int MAX_READS      = 4,
  parameter int MAX_WRITES     = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       test_en_i,
  input  logic       flush_req_i,
  output logic       idle_o,
  output logic       flush_ack_o,
  output logic [7:0] rd_cnt_o,
  output logic [7:0] wr_cnt_o,
  AXI_BUS.Slave      axi_slave,
  AXI_BUS.Master     axi_master
);
  localparam logic [7:0] MAX_RD = 8'(MAX_READS);
  localparam logic [7:0] MAX_WR = 8'(MAX_WRITES);
  localparam int unused_widths = AXI_ADDR_WIDTH + AXI_DATA_WIDTH + AXI_USER_WIDTH + AXI_ID_WIDTH;

  wire unused_test_en = test_en_i;

  logic [7:0] rd_cnt_reg, rd_cnt_next;
  logic [7:0] wr_cnt_reg, wr_cnt_next;
  logic       flush_ack_reg;
  logic       ar_allow, aw_allow;
  logic       rd_inc, rd_dec, wr_inc, wr_dec;

  // Allow depends only on the registered count, so a same-cycle completion
  // at the limit frees the slot one cycle later.
  assign ar_allow = (rd_cnt_reg != MAX_RD) & ~flush_req_i;
  assign aw_allow = (wr_cnt_reg != MAX_WR) & ~flush_req_i;

  assign axi_master.ar_valid  = axi_slave.ar_valid & ar_allow;
  assign axi_slave.ar_ready   = axi_master.ar_ready & ar_allow;
  assign axi_master.ar_id     = axi_slave.ar_id;
  assign axi_master.ar_addr   = axi_slave.ar_addr;
  assign axi_master.ar_len    = axi_slave.ar_len;
  assign axi_master.ar_size   = axi_slave.ar_size;
  assign axi_master.ar_burst  = axi_slave.ar_burst;
  assign axi_master.ar_lock   = axi_slave.ar_lock;
  assign axi_master.ar_cache  = axi_slave.ar_cache;
  assign axi_master.ar_prot   = axi_slave.ar_prot;
  assign axi_master.ar_qos    = axi_slave.ar_qos;
  assign axi_master.ar_region = axi_slave.ar_region;
  assign axi_master.ar_user   = axi_slave.ar_user;

  assign axi_master.aw_valid  = axi_slave.aw_valid & aw_allow;
  assign axi_slave.aw_ready   = axi_master.aw_ready & aw_allow;
  assign axi_master.aw_id     = axi_slave.aw_id;
  assign axi_master.aw_addr   = axi_slave.aw_addr;
  assign axi_master.aw_len    = axi_slave.aw_len;
  assign axi_master.aw_size   = axi_slave.aw_size;
  assign axi_master.aw_burst  = axi_slave.aw_burst;
  assign axi_master.aw_lock   = axi_slave.aw_lock;
  assign axi_master.aw_cache  = axi_slave.aw_cache;
  assign axi_master.aw_prot   = axi_slave.aw_prot;
  assign axi_master.aw_qos    = axi_slave.aw_qos;
  assign axi_master.aw_region = axi_slave.aw_region;
  assign axi_master.aw_user   = axi_slave.aw_user;

  assign axi_master.w_data  = axi_slave.w_data;
  assign axi_master.w_strb  = axi_slave.w_strb;
  assign axi_master.w_last  = axi_slave.w_last;
  assign axi_master.w_user  = axi_slave.w_user;
  assign axi_master.w_valid = axi_slave.w_valid;
  assign axi_slave.w_ready  = axi_master.w_ready;

  assign axi_slave.b_id      = axi_master.b_id;
  assign axi_slave.b_resp    = axi_master.b_resp;
  assign axi_slave.b_user    = axi_master.b_user;
  assign axi_slave.b_valid   = axi_master.b_valid;
  assign axi_master.b_ready  = axi_slave.b_ready;

  assign axi_slave.r_id      = axi_master.r_id;
  assign axi_slave.r_data    = axi_master.r_data;
  assign axi_slave.r_resp    = axi_master.r_resp;
  assign axi_slave.r_last    = axi_master.r_last;
  assign axi_slave.r_user    = axi_master.r_user;
  assign axi_slave.r_valid   = axi_master.r_valid;
  assign axi_master.r_ready  = axi_slave.r_ready;

  assign rd_inc = axi_master.ar_valid & axi_master.ar_ready;
  assign rd_dec = axi_master.r_valid & axi_master.r_ready & axi_master.r_last;
  assign wr_inc = axi_master.aw_valid & axi_master.aw_ready;
  assign wr_dec = axi_master.b_valid & axi_master.b_ready;

  // A completion with nothing outstanding leaves the counter at zero.
  always_comb begin
    rd_cnt_next = rd_cnt_reg;
    wr_cnt_next = wr_cnt_reg;
    if (rd_inc && !rd_dec) begin
      rd_cnt_next = rd_cnt_reg + 8'd1;
    end else if (rd_dec && !rd_inc && rd_cnt_reg != 8'd0) begin
      rd_cnt_next = rd_cnt_reg - 8'd1;
    end
    if (wr_inc && !wr_dec) begin
      wr_cnt_next = wr_cnt_reg + 8'd1;
    end else if (wr_dec && !wr_inc && wr_cnt_reg != 8'd0) begin
      wr_cnt_next = wr_cnt_reg - 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_cnt_reg    <= 8'd0;
      wr_cnt_reg    <= 8'd0;
      flush_ack_reg <= 1'b0;
    end else begin
      rd_cnt_reg    <= rd_cnt_next;
      wr_cnt_reg    <= wr_cnt_next;
      flush_ack_reg <= flush_req_i & idle_o;
    end
  end

  assign idle_o      = (rd_cnt_reg == 8'd0) && (wr_cnt_reg == 8'd0);
  assign flush_ack_o = flush_ack_reg;
  assign rd_cnt_o    = rd_cnt_reg;
  assign wr_cnt_o    = wr_cnt_reg;

  rd_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(rd_dec && rd_cnt_reg == 8'd0));
  wr_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(wr_dec && wr_cnt_reg == 8'd0));
endmodule
